// File: rtl/neuron_mac_pkg.sv
// Shared definitions for the neuron pre-activation sequencer.
//   - IEEE-754 single constants used by the sequencer and its testbenches
//   - sequencer FSM states and float-core FSM states
//   - fp_mul / fp_add: round-to-nearest-even single-precision arithmetic.
//     Zero/denormal operands are treated as zero and underflowing results
//     flush to signed zero; any NaN operand returns the canonical quiet NaN.
package neuron_mac_pkg;

    localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
    localparam logic [31:0] FP_ONE     = 32'h3f80_0000;
    localparam logic [31:0] FP_NEG_ONE = 32'hbf80_0000;
    localparam logic [31:0] FP_QNAN    = 32'h7fc0_0000;

    typedef enum logic [2:0] {
        ST_GET_PAIR,
        ST_MUL_SEND,
        ST_MUL_WAIT,
        ST_ADD_SEND,
        ST_ADD_WAIT,
        ST_PUT_Y
    } state_t;

    typedef enum logic { FP_OP_MUL, FP_OP_ADD } fp_op_t;
    typedef enum logic { CORE_IN, CORE_OUT } core_state_t;

    // Round a 24-bit significand (hidden bit at [23]) with guard/sticky bits
    // and pack; handles the carry out of rounding and exponent overflow/underflow.
    function automatic logic [31:0] fp_pack(input logic s, input logic signed [9:0] e,
                                            input logic [23:0] m, input logic g, input logic st);
        logic [24:0]       mr;
        logic signed [9:0] er;
        mr = {1'b0, m} + 25'(g & (st | m[0]));
        er = e;
        if (mr[24]) begin
            mr = mr >> 1;
            er = er + 10'sd1;
        end
        if (er >= 10'sd255) return {s, 8'hff, 23'h0};
        if (er <= 10'sd0)   return {s, 31'h0};
        return {s, er[7:0], mr[22:0]};
    endfunction

    function automatic logic fp_is_nan(input logic [31:0] f);
        return (f[30:23] == 8'hff) && (f[22:0] != 23'h0);
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic              s;
        logic [47:0]       p;
        logic signed [9:0] e;
        s = a[31] ^ b[31];
        if (fp_is_nan(a) || fp_is_nan(b)) return FP_QNAN;
        if (a[30:23] == 8'hff || b[30:23] == 8'hff) begin
            if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return FP_QNAN;
            return {s, 8'hff, 23'h0};
        end
        if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'h0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (p[47]) return fp_pack(s, e + 10'sd1, p[47:24], p[23], |p[22:0]);
        return fp_pack(s, e, p[46:23], p[22], |p[21:0]);
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       big, sml;
        logic [7:0]        d;
        logic [26:0]       mb, ms;
        logic [27:0]       sum;
        logic signed [9:0] e;
        if (fp_is_nan(a) || fp_is_nan(b)) return FP_QNAN;
        if (a[30:23] == 8'hff && b[30:23] == 8'hff && a[31] != b[31]) return FP_QNAN;
        if (a[30:23] == 8'hff) return a;
        if (b[30:23] == 8'hff) return b;
        if (a[30:23] == 8'h00 && b[30:23] == 8'h00) return {a[31] & b[31], 31'h0};
        if (a[30:23] == 8'h00) return b;
        if (b[30:23] == 8'h00) return a;
        // Order by magnitude so the subtraction below never goes negative.
        if (a[30:0] >= b[30:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        d  = big[30:23] - sml[30:23];
        mb = {1'b1, big[22:0], 3'b000};
        ms = {1'b1, sml[22:0], 3'b000};
        // Three extra low bits (guard, round, sticky) keep the result exactly roundable.
        if (d >= 8'd27) ms = 27'd1;
        else            ms = (ms >> d) | 27'(|(ms & ((27'd1 << d) - 27'd1)));
        sum = (big[31] == sml[31]) ? ({1'b0, mb} + {1'b0, ms}) : ({1'b0, mb} - {1'b0, ms});
        if (sum == 28'd0) return FP_ZERO;
        e = $signed({2'b00, big[30:23]});
        if (sum[27]) begin
            sum = {1'b0, sum[27:2], sum[1] | sum[0]};
            e   = e + 10'sd1;
        end else begin
            for (int i = 0; i < 26; i++) begin
                if (!sum[26]) begin
                    sum = sum << 1;
                    e   = e - 10'sd1;
                end
            end
        end
        return fp_pack(big[31], e, sum[26:3], sum[2], |sum[1:0]);
    endfunction

endpackage

// File: rtl/neuron_mac_fpu.sv
// Two-operand single-precision float core with stb/ack ports.
//   OP selects multiply or add. Operands a and b are accepted independently;
//   once both are held the result is computed into a register and offered
//   on o_z/o_z_stb until o_z is accepted.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   i_a, i_a_stb, o_a_ack operand a handshake
//   i_b, i_b_stb, o_b_ack operand b handshake
//   o_z, o_z_stb, i_z_ack result handshake
module neuron_mac_fpu
    import neuron_mac_pkg::*;
#(
    parameter fp_op_t OP = FP_OP_MUL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_a,
    input  logic        i_a_stb,
    output logic        o_a_ack,
    input  logic [31:0] i_b,
    input  logic        i_b_stb,
    output logic        o_b_ack,
    output logic [31:0] o_z,
    output logic        o_z_stb,
    input  logic        i_z_ack
);

    core_state_t r_state, w_state_nxt;
    logic        r_got_a, r_got_b;
    logic [31:0] r_a, r_b, r_z;

    always_ff @(posedge clk) begin
        if (rst) r_state <= CORE_IN;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_a_ack     = 1'b0;
        o_b_ack     = 1'b0;
        o_z_stb     = 1'b0;
        case (r_state)
            CORE_IN: begin
                o_a_ack = !r_got_a;
                o_b_ack = !r_got_b;
                if (r_got_a && r_got_b) w_state_nxt = CORE_OUT;
            end
            CORE_OUT: begin
                o_z_stb = 1'b1;
                if (i_z_ack) w_state_nxt = CORE_IN;
            end
            default: w_state_nxt = CORE_IN;
        endcase
    end

    assign o_z = r_z;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_got_a <= 1'b0;
            r_got_b <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_z     <= '0;
        end else begin
            if (i_a_stb && o_a_ack) begin
                r_a     <= i_a;
                r_got_a <= 1'b1;
            end
            if (i_b_stb && o_b_ack) begin
                r_b     <= i_b;
                r_got_b <= 1'b1;
            end
            if (r_state == CORE_IN && r_got_a && r_got_b) begin
                if (OP == FP_OP_MUL) r_z <= fp_mul(r_a, r_b);
                else                 r_z <= fp_add(r_a, r_b);
            end
            if (r_state == CORE_OUT && i_z_ack) begin
                r_got_a <= 1'b0;
                r_got_b <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// Single-neuron pre-activation sequencer: y = bias + sum(x_i * w_i).
// Pairs arrive serially; each is multiplied, then added into the running sum
// in fixed order ((bias+p0)+p1)+... . After N_INPUTS pairs y is offered
// downstream; no new pair is taken until y has been accepted.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   input_x, input_w                  activation / weight (IEEE-754 single)
//   input_bias                        bias, sampled only with pair 0
//   input_stb, input_ack              pair handshake
//   output_y, output_y_stb, output_y_ack  result handshake
// Handshake rule for every port here and on the cores: a word moves on a
// rising edge where stb and ack are both 1; the sender holds data and stb
// until then, the receiver drops ack the cycle after, and neither stb nor
// ack is ever a combinational function of the other.
module neuron_mac
    import neuron_mac_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_x,
    input  logic [31:0] input_w,
    input  logic [31:0] input_bias,
    input  logic        input_stb,
    output logic        input_ack,
    output logic [31:0] output_y,
    output logic        output_y_stb,
    input  logic        output_y_ack
);

    if (N_INPUTS < 1 || N_INPUTS > (1 << CNT_W)) begin : g_bad_n_inputs
        $error("neuron_mac: N_INPUTS must be in 1..2**CNT_W");
    end

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_x, r_w, r_acc, r_prod, r_y;
    logic               r_y_stb, r_sent_a, r_sent_b;
    logic               w_in_ack, w_a_done, w_b_done, w_last;
    logic               w_mul_a_stb, w_mul_b_stb, w_mul_a_ack, w_mul_b_ack;
    logic               w_mul_z_stb, w_mul_z_ack;
    logic               w_add_a_stb, w_add_b_stb, w_add_a_ack, w_add_b_ack;
    logic               w_add_z_stb, w_add_z_ack;
    logic [31:0]        w_mul_z, w_add_z;

    assign w_last       = (r_cnt == CNT_W'(N_INPUTS - 1));
    assign input_ack    = w_in_ack;
    assign output_y     = r_y;
    assign output_y_stb = r_y_stb;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_GET_PAIR;
        else     r_state <= w_state_nxt;
    end

    // r_sent_a/b remember which operand a core has already taken, so each
    // operand strobe drops independently; they are shared by both send states.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ack    = 1'b0;
        w_mul_a_stb = 1'b0;
        w_mul_b_stb = 1'b0;
        w_mul_z_ack = 1'b0;
        w_add_a_stb = 1'b0;
        w_add_b_stb = 1'b0;
        w_add_z_ack = 1'b0;
        w_a_done    = 1'b0;
        w_b_done    = 1'b0;
        case (r_state)
            ST_GET_PAIR: begin
                w_in_ack = !rst;
                if (input_stb && w_in_ack) w_state_nxt = ST_MUL_SEND;
            end
            ST_MUL_SEND: begin
                w_mul_a_stb = !r_sent_a;
                w_mul_b_stb = !r_sent_b;
                w_a_done    = r_sent_a | (w_mul_a_stb & w_mul_a_ack);
                w_b_done    = r_sent_b | (w_mul_b_stb & w_mul_b_ack);
                if (w_a_done && w_b_done) w_state_nxt = ST_MUL_WAIT;
            end
            ST_MUL_WAIT: begin
                w_mul_z_ack = 1'b1;
                if (w_mul_z_stb) w_state_nxt = ST_ADD_SEND;
            end
            ST_ADD_SEND: begin
                w_add_a_stb = !r_sent_a;
                w_add_b_stb = !r_sent_b;
                w_a_done    = r_sent_a | (w_add_a_stb & w_add_a_ack);
                w_b_done    = r_sent_b | (w_add_b_stb & w_add_b_ack);
                if (w_a_done && w_b_done) w_state_nxt = ST_ADD_WAIT;
            end
            ST_ADD_WAIT: begin
                w_add_z_ack = 1'b1;
                if (w_add_z_stb) w_state_nxt = w_last ? ST_PUT_Y : ST_GET_PAIR;
            end
            ST_PUT_Y: begin
                if (r_y_stb && output_y_ack) w_state_nxt = ST_GET_PAIR;
            end
            default: w_state_nxt = ST_GET_PAIR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_x      <= '0;
            r_w      <= '0;
            r_acc    <= FP_ZERO;
            r_prod   <= '0;
            r_y      <= '0;
            r_y_stb  <= 1'b0;
            r_sent_a <= 1'b0;
            r_sent_b <= 1'b0;
        end else begin
            case (r_state)
                ST_GET_PAIR: begin
                    if (input_stb && w_in_ack) begin
                        r_x <= input_x;
                        r_w <= input_w;
                        if (r_cnt == '0) r_acc <= input_bias;
                    end
                end
                ST_MUL_SEND, ST_ADD_SEND: begin
                    if (w_a_done && w_b_done) begin
                        r_sent_a <= 1'b0;
                        r_sent_b <= 1'b0;
                    end else begin
                        r_sent_a <= w_a_done;
                        r_sent_b <= w_b_done;
                    end
                end
                ST_MUL_WAIT: begin
                    if (w_mul_z_stb) r_prod <= w_mul_z;
                end
                ST_ADD_WAIT: begin
                    if (w_add_z_stb) begin
                        r_acc <= w_add_z;
                        if (w_last) begin
                            r_y     <= w_add_z;
                            r_y_stb <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_PUT_Y: begin
                    if (r_y_stb && output_y_ack) begin
                        r_y_stb <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    neuron_mac_fpu #(.OP(FP_OP_MUL)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .i_a     (r_x),
        .i_a_stb (w_mul_a_stb),
        .o_a_ack (w_mul_a_ack),
        .i_b     (r_w),
        .i_b_stb (w_mul_b_stb),
        .o_b_ack (w_mul_b_ack),
        .o_z     (w_mul_z),
        .o_z_stb (w_mul_z_stb),
        .i_z_ack (w_mul_z_ack)
    );

    neuron_mac_fpu #(.OP(FP_OP_ADD)) u_add (
        .clk     (clk),
        .rst     (rst),
        .i_a     (r_acc),
        .i_a_stb (w_add_a_stb),
        .o_a_ack (w_add_a_ack),
        .i_b     (r_prod),
        .i_b_stb (w_add_b_stb),
        .o_b_ack (w_add_b_ack),
        .o_z     (w_add_z),
        .o_z_stb (w_add_z_stb),
        .i_z_ack (w_add_z_ack)
    );

endmodule

// File: tb/tb_neuron_mac.sv
// Testbench for neuron_mac: directed vectors, random vectors against a
// real-arithmetic reference model, backpressure, mid-operation reset, and a
// second instance with a single input pair.
module tb_neuron_mac;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] input_x = '0, input_w = '0, input_bias = '0;
    logic        input_stb = 1'b0;
    logic        input_ack;
    logic [31:0] output_y;
    logic        output_y_stb;
    logic        output_y_ack = 1'b0;

    logic [31:0] input_x1 = '0, input_w1 = '0, input_bias1 = '0;
    logic        input_stb1 = 1'b0;
    logic        input_ack1;
    logic [31:0] output_y1;
    logic        output_y_stb1;
    logic        output_y_ack1 = 1'b1;

    logic [31:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic        stall_y = 1'b0;

    always #5 clk = ~clk;

    neuron_mac #(.N_INPUTS(4), .CNT_W(8)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .input_x      (input_x),
        .input_w      (input_w),
        .input_bias   (input_bias),
        .input_stb    (input_stb),
        .input_ack    (input_ack),
        .output_y     (output_y),
        .output_y_stb (output_y_stb),
        .output_y_ack (output_y_ack)
    );

    neuron_mac #(.N_INPUTS(1), .CNT_W(8)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .input_x      (input_x1),
        .input_w      (input_w1),
        .input_bias   (input_bias1),
        .input_stb    (input_stb1),
        .input_ack    (input_ack1),
        .output_y     (output_y1),
        .output_y_stb (output_y_stb1),
        .output_y_ack (output_y_ack1)
    );

    // ---------------- reference model (real arithmetic) ----------------
    function automatic real f2r(input logic [31:0] f);
        if (f[30:23] == 8'h00) return $bitstoreal({f[31], 63'b0});
        return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0});
    endfunction

    // Round a double to the nearest-even single (normal range expected).
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [24:0] m;
        int          e;
        d = $realtobits(r);
        if (d[62:0] == 63'b0) return {d[63], 31'b0};
        e = int'({21'b0, d[62:52]}) - 1023 + 127;
        m = {2'b01, d[51:29]} + 25'(d[28] & ((|d[27:0]) | d[29]));
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e >= 255) return {d[63], 8'hff, 23'h0};
        if (e <= 0)   return {d[63], 31'h0};
        return {d[63], 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] model_y(input logic [3:0][31:0] xs, input logic [3:0][31:0] ws,
                                            input logic [31:0] bias, input int n);
        logic [31:0] acc, p;
        acc = bias;
        for (int i = 0; i < n; i++) begin
            p   = r2f(f2r(xs[i]) * f2r(ws[i]));
            acc = r2f(f2r(acc) + f2r(p));
        end
        return acc;
    endfunction

    function automatic logic [31:0] rnd_f();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out", name);
    endtask

    // ---------------- drivers ----------------
    task automatic send_pair(input logic [31:0] x, input logic [31:0] w,
                             input logic [31:0] bias, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        input_x    = x;
        input_w    = w;
        input_bias = bias;
        input_stb  = 1'b1;
        n = 0;
        while (!input_ack && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!input_ack) fail_now("pair_accept");
        @(posedge clk);
        #1;
        input_stb  = 1'b0;
        input_x    = $urandom;
        input_w    = $urandom;
        input_bias = $urandom;
    endtask

    // Bias is only driven with pair 0; later pairs carry junk in its place.
    task automatic send_vec(input logic [3:0][31:0] xs, input logic [3:0][31:0] ws,
                            input logic [31:0] bias, input logic [31:0] expv, input int gap_max);
        exp_q.push_back(expv);
        for (int i = 0; i < 4; i++)
            send_pair(xs[i], ws[i], (i == 0) ? bias : 32'($urandom), $urandom_range(0, gap_max));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_now("drain");
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_single(input logic [31:0] x, input logic [31:0] w,
                              input logic [31:0] bias, input logic [31:0] expv);
        int n;
        @(negedge clk);
        input_x1    = x;
        input_w1    = w;
        input_bias1 = bias;
        input_stb1  = 1'b1;
        n = 0;
        while (!input_ack1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!input_ack1) fail_now("n1_accept");
        @(posedge clk);
        #1;
        input_stb1 = 1'b0;
        n = 0;
        @(negedge clk);
        while (!output_y_stb1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("n1_stb", 32'(output_y_stb1), 32'd1);
        check("n1_y", output_y1, expv);
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic        pending;
        logic [31:0] held_y;
        logic [31:0] expv;
        pending = 1'b0;
        held_y  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                output_y_ack = 1'b0;
                pending      = 1'b0;
            end else if (output_y_stb) begin
                if (pending) check("y_stable", output_y, held_y);
                check("no_overlap_input_ack", 32'(input_ack), 32'd0);
                if (!stall_y && $urandom_range(0, 2) != 0) begin
                    output_y_ack = 1'b1;
                    pending      = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_y: got %h, expected no output", output_y);
                    end else begin
                        expv = exp_q.pop_front();
                        check("y_value", output_y, expv);
                    end
                end else begin
                    output_y_ack = 1'b0;
                    pending      = 1'b1;
                    held_y       = output_y;
                end
            end else begin
                output_y_ack = 1'b0;
                pending      = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- main stimulus ----------------
    initial begin : main
        logic [3:0][31:0] xs, ws;
        logic [31:0]      bias, expv;
        int               n;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_input_ack", 32'(input_ack), 32'd0);
        check("rst_y_stb", 32'(output_y_stb), 32'd0);
        check("rst_y", output_y, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_input_ack", 32'(input_ack), 32'd1);
        check("post_rst_y_stb", 32'(output_y_stb), 32'd0);

        // 1+2+3+4 = 10.0
        xs = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3f800000};
        ws = {4{32'h3f800000}};
        send_vec(xs, ws, 32'h0, 32'h41200000, 0);
        wait_drain();

        // 1 + 2 - 2 + 2 - 2 = 1.0, with random input gaps
        xs = {32'h40000000, 32'h3f000000, 32'hbf800000, 32'h3f800000};
        ws = {32'hbf800000, 32'h40800000, 32'h40000000, 32'h40000000};
        send_vec(xs, ws, 32'h3f800000, 32'h3f800000, 7);
        wait_drain();

        // Backpressure: hold the result for 20 cycles
        stall_y = 1'b1;
        xs = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3f800000};
        ws = {4{32'h3f800000}};
        send_vec(xs, ws, 32'h0, 32'h41200000, 2);
        n = 0;
        while (!output_y_stb && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!output_y_stb) fail_now("stall_wait_y");
        repeat (20) @(negedge clk);
        stall_y = 1'b0;
        wait_drain();

        // Reset after two pairs of a large vector; nothing of it may survive
        send_pair(32'h42c80000, 32'h42c80000, 32'h42c80000, 0);
        send_pair(32'h42c80000, 32'h42c80000, 32'h42c80000, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        xs = {4{32'h3f000000}};
        ws = {4{32'h3f000000}};
        send_vec(xs, ws, 32'h3f000000, 32'h3fc00000, 3);
        wait_drain();

        // 4 * (1 * -0.5) = -2.0
        xs = {4{32'h3f800000}};
        ws = {4{32'hbf000000}};
        send_vec(xs, ws, 32'h0, 32'hc0000000, 1);
        wait_drain();

        // Back-to-back vectors, bias re-sampled for the second
        xs = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3f800000};
        ws = {4{32'h3f800000}};
        send_vec(xs, ws, 32'h0, 32'h41200000, 0);
        xs = {32'h40000000, 32'h3f000000, 32'hbf800000, 32'h3f800000};
        ws = {32'hbf800000, 32'h40800000, 32'h40000000, 32'h40000000};
        send_vec(xs, ws, 32'h3f800000, 32'h3f800000, 0);
        wait_drain();

        // Random vectors against the reference model
        for (int v = 0; v < 20; v++) begin
            for (int i = 0; i < 4; i++) begin
                xs[i] = rnd_f();
                ws[i] = rnd_f();
            end
            bias = rnd_f();
            expv = model_y(xs, ws, bias, 4);
            send_vec(xs, ws, bias, expv, 3);
        end
        wait_drain();

        // Single-pair neuron: 1.0 * 2.0 + 0.5 = 2.5, then random pairs
        run_single(32'h3f800000, 32'h40000000, 32'h3f000000, 32'h40200000);
        for (int v = 0; v < 4; v++) begin
            xs[0] = rnd_f();
            ws[0] = rnd_f();
            bias  = rnd_f();
            run_single(xs[0], ws[0], bias, model_y(xs, ws, bias, 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
